draw_figure_ctl: RTL and testbench
==================================

Name: draw_figure_ctl

Overview:
- Requester side of the figure-ROM read interface. For each pixel it turns the VGA beam position and the figure's on-screen position into a ROM address.
- It then takes back the 12-bit colour the ROM returns one cycle later and overlays it on the incoming background stream.
- The VGA timing signals are re-aligned so that timing and colour leave the block together.
- Sits in the draw chain between the background/level drawer and the next overlay stage, with one instance per player figure.

Parameters:
- FIG_W, 26, figure width in pixels.
- FIG_H, 26, figure height in pixels (19 for the water figure).
- KEY_COLOR, 12'hF0F, transparent colour; ROM pixels equal to this pass the background through.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  beam x
- vcount_in  in  11  beam y
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blank
- vblnk_in  in  1  vertical blank
- rgb_in  in  12  background colour
- fig_x  in  11  requested figure left edge
- fig_y  in  11  requested figure top edge
- mirror  in  1  draw the figure horizontally flipped (facing left)
- rom_addr  out  12  address to the figure ROM
- rom_rgb  in  12  ROM data, valid 1 cycle after rom_addr
- hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out  out  11/11/1/1/1/1  delayed timing
- rgb_out  out  12  composited colour

Behaviour:
- Reset (rst_n=0, async): every output is 0, all pipeline registers are 0, and the latched position is (0,0).
- Position latch:
  - fig_x, fig_y and mirror are captured into internal registers only on the cycle where vblnk_in goes 0→1 (rising edge detected against a registered copy).
  - This prevents tearing mid-frame.
  - Changes outside that edge have no effect until the next frame.
- Stage 1 (cycle N+1):
  - in_box = hcount_in ≥ px, hcount_in < px+FIG_W, vcount_in ≥ py, vcount_in < py+FIG_H, and blanking inactive.
  - All comparisons are done at 12-bit width so px+FIG_W cannot wrap.
  - col = hcount_in−px, or FIG_W−1−(hcount_in−px) when mirrored.
  - row = vcount_in−py.
  - rom_addr is registered as row*FIG_W+col when in_box, and 0 otherwise.
  - in_box is registered.
- Stage 2 (N+2): the ROM presents rom_rgb, and in_box is delayed one more cycle.
- Stage 3 (N+3): rgb_out = rom_rgb if in_box_d2 and rom_rgb≠KEY_COLOR, else rgb_in delayed by 3.
- Latency:
  - All timing outputs and rgb_out are exactly 3 cycles after the corresponding inputs.
  - rom_addr is 1 cycle after.
- Boundaries:
  - A figure that is partially off-screen (px+FIG_W > 800) draws only its visible columns, with no wrap to the left edge.
  - Maximum address is FIG_W*FIG_H−1; no address ≥ FIG_W*FIG_H is ever issued.
  - During blanking, rgb_out = 0 regardless of the figure.
- Reset released mid-frame: output resumes with position (0,0) until the next vblnk rising edge latches new values.

Decomposition:
- vga_pkg (existing):
  - holds HOR_PIXELS=800, VER_PIXELS=600 and the timing widths.
  - add FIG_ADDR_W=12 and the default KEY_COLOR.
- Sub-module: reuse the generic delay (WIDTH, CLK_DEL) block for the 3-cycle timing/rgb_in alignment.
- Address arithmetic and compositing stay in draw_figure_ctl.

Test Plan:
- Reset: hold rst_n=0 for 5 cycles with active inputs → all outputs 0, and rom_addr 0 during reset.
- Position latch: fig_x=100, fig_y=200, pulse vblnk rising → at hcount=100, vcount=200 rom_addr=0 one cycle later; at (125,225) rom_addr=675.
- Mirror: mirror=1 at latch, beam at (100,200) → rom_addr=25; at (125,200) → rom_addr=0.
- Transparency and latency:
  - ROM model returns KEY_COLOR at address 0 → rgb_out equals rgb_in from 3 cycles earlier.
  - ROM model returns 12'h0F0 → rgb_out=12'h0F0.
  - Check hsync_out against hsync_in delayed by exactly 3.
- Mid-frame change: change fig_x from 100 to 300 during active video → the current frame still draws at 100; the next frame draws at 300.
- Right edge: fig_x=790 → pixels only at hcount 790..799, rom_addr max 9+row*26, and no pixels at hcount 0..15.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the bundled timing/colour word used by draw stages.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;
  localparam int HCOUNT_W   = 11;
  localparam int VCOUNT_W   = 11;
  localparam int RGB_W      = 12;

  localparam int FIG_ADDR_W = 12;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEFAULT = 12'hF0F;

  typedef struct packed {
    logic [HCOUNT_W-1:0] hcount;
    logic [VCOUNT_W-1:0] vcount;
    logic                hsync;
    logic                vsync;
    logic                hblnk;
    logic                vblnk;
    logic [RGB_W-1:0]    rgb;
  } vga_bus_t;

  localparam int VGA_BUS_W = $bits(vga_bus_t);

  // Linear ROM address of a figure pixel stored row-major.
  function automatic logic [FIG_ADDR_W-1:0] fig_addr(
    input logic [FIG_ADDR_W-1:0] row,
    input logic [FIG_ADDR_W-1:0] col,
    input int                    width
  );
    return FIG_ADDR_W'(row * FIG_ADDR_W'(width)) + col;
  endfunction

endpackage

// File: rtl/draw_figure_ctl_delay.sv
// Generic register delay line: dout is din delayed by CLK_DEL clock cycles.
module draw_figure_ctl_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [CLK_DEL];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLK_DEL; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < CLK_DEL; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_figure_ctl.sv
// Figure overlay stage: issues figure-ROM addresses from the beam position and
// composites the returned colour over the background, keeping timing aligned.
module draw_figure_ctl
  import vga_pkg::*;
#(
  parameter int               FIG_W     = 26,
  parameter int               FIG_H     = 26,
  parameter logic [RGB_W-1:0] KEY_COLOR = KEY_COLOR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [HCOUNT_W-1:0]   hcount_in,
  input  logic [VCOUNT_W-1:0]   vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [RGB_W-1:0]      rgb_in,
  input  logic [HCOUNT_W-1:0]   fig_x,
  input  logic [VCOUNT_W-1:0]   fig_y,
  input  logic                  mirror,
  output logic [FIG_ADDR_W-1:0] rom_addr,
  input  logic [RGB_W-1:0]      rom_rgb,
  output logic [HCOUNT_W-1:0]   hcount_out,
  output logic [VCOUNT_W-1:0]   vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [RGB_W-1:0]      rgb_out
);

  logic                vblnk_prev;
  logic [HCOUNT_W-1:0] pos_x;
  logic [VCOUNT_W-1:0] pos_y;
  logic                pos_mirror;

  // Position only moves at the start of vertical blanking so a frame never tears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vblnk_prev <= 1'b0;
      pos_x      <= '0;
      pos_y      <= '0;
      pos_mirror <= 1'b0;
    end else begin
      vblnk_prev <= vblnk_in;
      if (vblnk_in && !vblnk_prev) begin
        pos_x      <= fig_x;
        pos_y      <= fig_y;
        pos_mirror <= mirror;
      end
    end
  end

  logic [FIG_ADDR_W-1:0] hc_w, vc_w, px_w, py_w, x_end, y_end;
  logic [FIG_ADDR_W-1:0] dx, dy, col;
  logic                  in_box;
  logic [FIG_ADDR_W-1:0] addr_next;

  // One extra bit of width keeps px+FIG_W from wrapping near the right edge.
  always_comb begin
    hc_w   = {1'b0, hcount_in};
    vc_w   = {1'b0, vcount_in};
    px_w   = {1'b0, pos_x};
    py_w   = {1'b0, pos_y};
    x_end  = px_w + FIG_ADDR_W'(FIG_W);
    y_end  = py_w + FIG_ADDR_W'(FIG_H);
    in_box = (hc_w >= px_w) && (hc_w < x_end) &&
             (vc_w >= py_w) && (vc_w < y_end) &&
             !hblnk_in && !vblnk_in;
    dx     = hc_w - px_w;
    dy     = vc_w - py_w;
    col    = pos_mirror ? (FIG_ADDR_W'(FIG_W - 1) - dx) : dx;
    addr_next = in_box ? fig_addr(dy, col, FIG_W) : '0;
  end

  logic in_box_d1, in_box_d2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      in_box_d1 <= 1'b0;
      in_box_d2 <= 1'b0;
    end else begin
      rom_addr  <= addr_next;
      in_box_d1 <= in_box;
      in_box_d2 <= in_box_d1;
    end
  end

  vga_bus_t bus_in, bus_d2;

  assign bus_in = '{hcount: hcount_in, vcount: vcount_in,
                    hsync:  hsync_in,  vsync:  vsync_in,
                    hblnk:  hblnk_in,  vblnk:  vblnk_in,
                    rgb:    rgb_in};

  // Two cycles here plus the output register below give the 3-cycle alignment.
  draw_figure_ctl_delay #(
    .WIDTH   (VGA_BUS_W),
    .CLK_DEL (2)
  ) u_timing_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (bus_in),
    .dout  (bus_d2)
  );

  logic [RGB_W-1:0] rgb_next;

  always_comb begin
    rgb_next = bus_d2.rgb;
    if (bus_d2.hblnk || bus_d2.vblnk) begin
      rgb_next = '0;
    end else if (in_box_d2 && (rom_rgb != KEY_COLOR)) begin
      rgb_next = rom_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= bus_d2.hcount;
      vcount_out <= bus_d2.vcount;
      hsync_out  <= bus_d2.hsync;
      vsync_out  <= bus_d2.vsync;
      hblnk_out  <= bus_d2.hblnk;
      vblnk_out  <= bus_d2.vblnk;
      rgb_out    <= rgb_next;
    end
  end

endmodule

// File: tb/tb_draw_figure_ctl.sv
// Self-checking bench for draw_figure_ctl: pixel-level reference model plus directed literal checks.
module tb_draw_figure_ctl;

  localparam int          FW  = 26;
  localparam int          FH  = 26;
  localparam logic [11:0] KEY = 12'hF0F;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in, fig_x, fig_y;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, mirror;
  logic [11:0] rgb_in, rom_rgb, rom_addr, rgb_out;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;
  logic [11:0] rom_zero_val = KEY;

  always #5 clk = ~clk;

  draw_figure_ctl dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .fig_x(fig_x), .fig_y(fig_y), .mirror(mirror),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    if (a == 12'd0) return rom_zero_val;
    if ((a % 5) == 0) return KEY;
    return 12'((a * 37) + 12'h155);
  endfunction

  // Synchronous figure ROM: data one cycle after address.
  initial rom_rgb = '0;
  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each sampled pixel is reduced to what it should produce.
  typedef struct {
    int hc, vc, rgb, addr;
    bit hs, vs, hb, vb, inb;
  } smp_t;

  smp_t hist [3];
  smp_t s_new;
  int   m_px, m_py, m_col;
  bit   m_mir, m_prev_vb;

  task automatic clear_model();
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    m_px = 0; m_py = 0; m_mir = 0; m_prev_vb = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_model();
    end else begin
      s_new.hc  = int'(hcount_in);
      s_new.vc  = int'(vcount_in);
      s_new.rgb = int'(rgb_in);
      s_new.hs  = hsync_in;
      s_new.vs  = vsync_in;
      s_new.hb  = hblnk_in;
      s_new.vb  = vblnk_in;
      s_new.inb = !hblnk_in && !vblnk_in &&
                  s_new.hc >= m_px && s_new.hc < m_px + FW &&
                  s_new.vc >= m_py && s_new.vc < m_py + FH;
      m_col = s_new.hc - m_px;
      if (m_mir) m_col = FW - 1 - m_col;
      s_new.addr = s_new.inb ? (s_new.vc - m_py) * FW + m_col : 0;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = s_new;
      if (vblnk_in && !m_prev_vb) begin
        m_px = int'(fig_x); m_py = int'(fig_y); m_mir = mirror;
      end
      m_prev_vb = vblnk_in;
    end
  end

  int exp_rgb;
  always @(negedge clk) begin
    if (cmp_en) begin
      if (!rst_n) begin
        chk("reset_timing", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, 64'd0);
        chk("reset_rgb_addr", {rgb_out, rom_addr}, 64'd0);
      end else begin
        if (hist[2].hb || hist[2].vb) exp_rgb = 0;
        else if (hist[2].inb && rom_fn(12'(hist[2].addr)) != KEY) exp_rgb = int'(rom_fn(12'(hist[2].addr)));
        else exp_rgb = hist[2].rgb;
        chk("rom_addr", rom_addr, hist[0].addr);
        chk("hcount_out", hcount_out, hist[2].hc);
        chk("vcount_out", vcount_out, hist[2].vc);
        chk("sync_blank_out", {hsync_out, vsync_out, hblnk_out, vblnk_out},
            {hist[2].hs, hist[2].vs, hist[2].hb, hist[2].vb});
        chk("rgb_out", rgb_out, exp_rgb);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beam(input int hc, input int vc, input bit hb, input bit vb, input logic [11:0] rgb);
    hcount_in = 11'(hc); vcount_in = 11'(vc);
    hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
  endtask

  task automatic latch(input int x, input int y, input bit mir);
    fig_x = 11'(x); fig_y = 11'(y); mirror = mir;
    beam(0, 0, 1, 0, 12'h000); step();
    beam(0, 0, 1, 1, 12'h000); step();
    beam(0, 0, 1, 0, 12'h000); step();
  endtask

  task automatic idle(input int n);
    beam(0, 0, 1, 0, 12'h000);
    hsync_in = 0; vsync_in = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  int fx, fy, h0, h1, v0, v1;

  initial begin
    rst_n = 0;
    hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0;
    fig_x = '0; fig_y = '0; mirror = 0;
    clear_model();
    step();
    cmp_en = 1'b1;

    // Reset held with an active-looking beam.
    fig_x = 11'd5; fig_y = 11'd5;
    for (int i = 0; i < 5; i++) begin
      beam(i + 5, 6, 0, i[0], 12'($urandom));
      hsync_in = 1; vsync_in = 1;
      step();
      chk("reset_rom_addr_lit", rom_addr, 12'd0);
    end
    idle(1);
    rst_n = 1;
    // Position (0,0) until the first latch: pixel (3,2) -> address 2*26+3.
    beam(3, 2, 0, 0, 12'h111); step();
    chk("post_reset_origin", rom_addr, 12'd55);
    idle(3);

    latch(100, 200, 0);
    beam(100, 200, 0, 0, 12'h321); step();
    chk("latch_origin", rom_addr, 12'd0);
    beam(125, 225, 0, 0, 12'h321); step();
    chk("latch_corner", rom_addr, 12'd675);
    beam(126, 225, 0, 0, 12'h321); step();
    chk("right_of_box", rom_addr, 12'd0);
    idle(3);

    latch(100, 200, 1);
    beam(100, 200, 0, 0, 12'h000); step();
    chk("mirror_left", rom_addr, 12'd25);
    beam(125, 200, 0, 0, 12'h000); step();
    chk("mirror_right", rom_addr, 12'd0);
    beam(101, 201, 0, 0, 12'h000); step();
    chk("mirror_row1", rom_addr, 12'd50);
    idle(3);

    latch(100, 200, 0);
    rom_zero_val = KEY;
    beam(100, 200, 0, 0, 12'h123); hsync_in = 1; step();
    idle(1);
    chk("hsync_at_2", hsync_out, 1'b0);
    step();
    chk("transparent_bg", rgb_out, 12'h123);
    chk("hsync_at_3", hsync_out, 1'b1);
    step();
    chk("hsync_at_4", hsync_out, 1'b0);
    idle(2);
    rom_zero_val = 12'h0F0;
    idle(1);
    beam(100, 200, 0, 0, 12'h123); step();
    idle(2);
    chk("opaque_fig", rgb_out, 12'h0F0);
    beam(100, 200, 1, 0, 12'hABC); step();
    idle(2);
    chk("blank_black", rgb_out, 12'h000);

    // Mid-frame move only takes effect after the next vblnk rising edge.
    fig_x = 11'd300;
    beam(101, 200, 0, 0, 12'h000); step();
    chk("midframe_old", rom_addr, 12'd1);
    beam(301, 200, 0, 0, 12'h000); step();
    chk("midframe_new_ignored", rom_addr, 12'd0);
    latch(300, 200, 0);
    beam(101, 200, 0, 0, 12'h000); step();
    chk("nextframe_old_gone", rom_addr, 12'd0);
    beam(301, 200, 0, 0, 12'h000); step();
    chk("nextframe_new", rom_addr, 12'd1);
    idle(3);

    latch(790, 200, 0);
    beam(799, 200, 0, 0, 12'h000); step();
    chk("edge_last_col", rom_addr, 12'd9);
    beam(799, 201, 0, 0, 12'h000); step();
    chk("edge_row1", rom_addr, 12'd35);
    beam(0, 200, 0, 0, 12'h456); step();
    chk("edge_no_wrap0", rom_addr, 12'd0);
    beam(15, 200, 0, 0, 12'h456); step();
    chk("edge_no_wrap15", rom_addr, 12'd0);
    step();
    chk("edge_wrap_bg", rgb_out, 12'h456);
    idle(3);

    // Random frames: scan a window around the figure, with random moves and blanking.
    for (int f = 0; f < 16; f++) begin
      case (f % 4)
        0: fx = 790 + int'($urandom_range(0, 9));
        1: fx = int'($urandom_range(0, 3));
        default: fx = int'($urandom_range(0, 799));
      endcase
      fy = int'($urandom_range(0, 580));
      fig_x = 11'(fx); fig_y = 11'(fy); mirror = $urandom_range(0, 1) == 1;
      beam(0, 0, 1, 1, 12'h000); step(); step();
      rom_zero_val = ($urandom_range(0, 1) == 1) ? KEY : 12'(($urandom_range(0, 4094)));
      step();
      h0 = (fx < 4) ? 0 : fx - 4;
      h1 = fx + FW + 4;
      v0 = (fy < 2) ? 0 : fy - 2;
      v1 = fy + FH + 1;
      for (int v = v0; v <= v1; v++) begin
        idle(2);
        for (int h = h0; h <= h1; h++) begin
          beam(h % 800, v % 600, ($urandom_range(0, 15) == 0), 0, 12'($urandom));
          hsync_in = $urandom_range(0, 1) == 1;
          vsync_in = $urandom_range(0, 1) == 1;
          if ($urandom_range(0, 63) == 0) begin
            fig_x = 11'($urandom_range(0, 799));
            fig_y = 11'($urandom_range(0, 599));
            mirror = ~mirror;
          end
          step();
        end
      end
      idle(4);
    end

    idle(4);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
